// File: rtl/vga_timing_controller.sv
// VGA 640x480 timing generator running at the 50 MHz system clock (2 clocks
// per pixel). Owns the horizontal/vertical counters and decodes sync,
// active-video window and pixel coordinates. A stop request lets the current
// frame drain before returning to idle.
module vga_timing_controller #(
  parameter int unsigned H_TOTAL          = 1600,
  parameter int unsigned H_SYNC_HIGH_LAST = 1408,
  parameter int unsigned H_VIS_START      = 96,
  parameter int unsigned H_VIS_END        = 1376,
  parameter int unsigned V_TOTAL          = 521,
  parameter int unsigned V_SYNC_LINES     = 2,
  parameter int unsigned V_VIS_START      = 31,
  parameter int unsigned V_VIS_END        = 511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [10:0] cntHorizontal,
  output logic [9:0]  cntVertical,
  output logic        HSync,
  output logic        VSync,
  output logic        videoOn,
  output logic        pixelTick,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        frameStart,
  output logic        lineEnd,
  output logic        busy
);

  // Sized copies of the timing parameters so every compare is width-matched.
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC  = 11'(H_SYNC_HIGH_LAST);
  localparam logic [10:0] H_VS    = 11'(H_VIS_START);
  localparam logic [10:0] H_VE    = 11'(H_VIS_END);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC  = 10'(V_SYNC_LINES);
  localparam logic [9:0]  V_VS    = 10'(V_VIS_START);
  localparam logic [9:0]  V_VE    = 10'(V_VIS_END);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [10:0] h_nxt, h_off;
  logic [9:0]  v_nxt;
  logic        last_h, last_v, run_nxt;
  logic        h_vis, v_vis;
  logic        hs_nxt, vs_nxt, vo_nxt, pt_nxt, fs_nxt, le_nxt;
  logic [9:0]  px_nxt, py_nxt;

  // Next state and next counter values; outputs are decoded from these so the
  // registered outputs always describe the registered counters.
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    last_h    = (cntHorizontal == H_LAST);
    last_v    = (cntVertical == V_LAST);
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN, DRAIN: begin
        if (last_h) begin
          h_nxt = '0;
          v_nxt = last_v ? '0 : cntVertical + 10'd1;
        end else begin
          h_nxt = cntHorizontal + 11'd1;
          v_nxt = cntVertical;
        end
        // Only a draining frame may stop, and only on its very last clock.
        if (state == DRAIN && last_h && last_v && !enable) state_nxt = IDLE;
        else state_nxt = enable ? RUN : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
    run_nxt = (state_nxt != IDLE);
  end

  // Output decode of the next counter values; idle forces reset values.
  always_comb begin
    h_vis  = run_nxt && (h_nxt >= H_VS) && (h_nxt < H_VE);
    v_vis  = run_nxt && (v_nxt >= V_VS) && (v_nxt < V_VE);
    h_off  = h_nxt - H_VS;
    vo_nxt = h_vis && v_vis;
    hs_nxt = !run_nxt || ((h_nxt != '0) && (h_nxt <= H_SYNC));
    vs_nxt = !run_nxt || (v_nxt >= V_SYNC);
    pt_nxt = vo_nxt && !h_off[0];
    px_nxt = vo_nxt ? h_off[10:1] : '0;
    py_nxt = v_vis ? (v_nxt - V_VS) : '0;
    fs_nxt = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    le_nxt = run_nxt && (h_nxt == H_LAST);
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cntHorizontal <= '0;
      cntVertical   <= '0;
      HSync         <= 1'b1;
      VSync         <= 1'b1;
      videoOn       <= 1'b0;
      pixelTick     <= 1'b0;
      pixelX        <= '0;
      pixelY        <= '0;
      frameStart    <= 1'b0;
      lineEnd       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cntHorizontal <= h_nxt;
      cntVertical   <= v_nxt;
      HSync         <= hs_nxt;
      VSync         <= vs_nxt;
      videoOn       <= vo_nxt;
      pixelTick     <= pt_nxt;
      pixelX        <= px_nxt;
      pixelY        <= py_nxt;
      frameStart    <= fs_nxt;
      lineEnd       <= le_nxt;
      busy          <= run_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller. Instance "a" uses the real
// 640x480 timing for line-level checks; instance "b" uses a shrunken timing
// (20x12) so whole frames, drain and restart fit in a short run.
module tb_vga_timing_controller;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Instance a: full timing
  logic        rst_a, en_a;
  logic [10:0] h_a;
  logic [9:0]  v_a, px_a, py_a;
  logic        hs_a, vs_a, vo_a, pt_a, fs_a, le_a, bz_a;

  vga_timing_controller dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a),
    .cntHorizontal(h_a), .cntVertical(v_a), .HSync(hs_a), .VSync(vs_a),
    .videoOn(vo_a), .pixelTick(pt_a), .pixelX(px_a), .pixelY(py_a),
    .frameStart(fs_a), .lineEnd(le_a), .busy(bz_a)
  );

  // Instance b: 20 clocks/line (vis 4..13), 12 lines (vsync 0..1, vis 3..9)
  logic        rst_b, en_b;
  logic [10:0] h_b;
  logic [9:0]  v_b, px_b, py_b;
  logic        hs_b, vs_b, vo_b, pt_b, fs_b, le_b, bz_b;

  vga_timing_controller #(
    .H_TOTAL(20), .H_SYNC_HIGH_LAST(16), .H_VIS_START(4), .H_VIS_END(14),
    .V_TOTAL(12), .V_SYNC_LINES(2), .V_VIS_START(3), .V_VIS_END(10)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b),
    .cntHorizontal(h_b), .cntVertical(v_b), .HSync(hs_b), .VSync(vs_b),
    .videoOn(vo_b), .pixelTick(pt_b), .pixelX(px_b), .pixelY(py_b),
    .frameStart(fs_b), .lineEnd(le_b), .busy(bz_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // Advance n edges, then settle 1 time unit past the edge for sampling/driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hs_hi, hs_bad, le_cnt, le_h, vs_lo, vo_cnt;
  int pt_cnt, py_bad;
  int vo95, vo96, px96, pt96, pt97, px1375, pt1375, vo1375, vo1376;
  int vsb_bad, vo_late, py9, fs_cnt, vob_cnt;

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    tick(3);
    chk("rst_h", h_a, 0);
    chk("rst_v", v_a, 0);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_busy", bz_a, 0);
    chk("rst_fs", fs_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(2);
    chk("idle_busy", bz_a, 0);
    chk("idle_le", le_a, 0);

    // Start: first RUN cycle shows 0/0 with frameStart
    en_a = 1'b1;
    tick(1);
    chk("start_h", h_a, 0);
    chk("start_v", v_a, 0);
    chk("start_fs", fs_a, 1);
    chk("start_hs", hs_a, 0);
    chk("start_vs", vs_a, 0);
    chk("start_busy", bz_a, 1);

    // Line 0: HSync high exactly for h=1..1408, lineEnd only at 1599
    hs_hi = 0; hs_bad = 0; le_cnt = 0; le_h = -1; vs_lo = 0; vo_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (hs_a) hs_hi++;
      if (hs_a != (h_a >= 11'd1 && h_a <= 11'd1408)) hs_bad++;
      if (le_a) begin le_cnt++; le_h = int'(h_a); end
      if (!vs_a) vs_lo++;
      if (vo_a) vo_cnt++;
      tick(1);
    end
    chk("l0_hs_high", hs_hi, 1408);
    chk("l0_hs_shape", hs_bad, 0);
    chk("l0_le_cnt", le_cnt, 1);
    chk("l0_le_h", le_h, 1599);
    chk("l0_vs_low", vs_lo, 1600);
    chk("l0_vo", vo_cnt, 0);
    chk("l1_h", h_a, 0);
    chk("l1_v", v_a, 1);
    chk("l1_vs", vs_a, 0);
    chk("l1_fs", fs_a, 0);

    tick(1600);
    chk("l2_v", v_a, 2);
    chk("l2_vs", vs_a, 1);

    tick(29 * 1600);
    chk("l31_v", v_a, 31);
    chk("l31_h0_vo", vo_a, 0);

    // Line 31: first visible line
    pt_cnt = 0; vo_cnt = 0; py_bad = 0;
    vo95 = -1; vo96 = -1; px96 = -1; pt96 = -1; pt97 = -1;
    px1375 = -1; pt1375 = -1; vo1375 = -1; vo1376 = -1;
    for (int i = 0; i < 1600; i++) begin
      if (pt_a) pt_cnt++;
      if (vo_a) vo_cnt++;
      if (py_a != 10'd0) py_bad++;
      case (h_a)
        11'd95:   vo95 = int'(vo_a);
        11'd96:   begin vo96 = int'(vo_a); px96 = int'(px_a); pt96 = int'(pt_a); end
        11'd97:   pt97 = int'(pt_a);
        11'd1375: begin px1375 = int'(px_a); pt1375 = int'(pt_a); vo1375 = int'(vo_a); end
        11'd1376: vo1376 = int'(vo_a);
        default: ;
      endcase
      tick(1);
    end
    chk("l31_vo95", vo95, 0);
    chk("l31_vo96", vo96, 1);
    chk("l31_px96", px96, 0);
    chk("l31_pt96", pt96, 1);
    chk("l31_pt97", pt97, 0);
    chk("l31_px1375", px1375, 639);
    chk("l31_pt1375", pt1375, 0);
    chk("l31_vo1375", vo1375, 1);
    chk("l31_vo1376", vo1376, 0);
    chk("l31_ticks", pt_cnt, 640);
    chk("l31_vo_cnt", vo_cnt, 1280);
    chk("l31_py", py_bad, 0);
    chk("l32_v", v_a, 32);
    chk("l32_py", py_a, 1);

    // Mid-frame reset with enable held high
    tick(700);
    chk("pre_rst_h", h_a, 700);
    rst_a = 1'b1;
    tick(1);
    chk("mrst_h", h_a, 0);
    chk("mrst_v", v_a, 0);
    chk("mrst_hs", hs_a, 1);
    chk("mrst_vs", vs_a, 1);
    chk("mrst_busy", bz_a, 0);
    chk("mrst_fs", fs_a, 0);
    rst_a = 1'b0;
    tick(1);
    chk("rerun_h", h_a, 0);
    chk("rerun_v", v_a, 0);
    chk("rerun_fs", fs_a, 1);
    chk("rerun_busy", bz_a, 1);

    // Instance b: idle the whole time so far
    chk("b_idle_busy", bz_b, 0);
    en_b = 1'b1;
    tick(1);
    chk("b_start_fs", fs_b, 1);

    // Full small frame
    vsb_bad = 0; vo_late = 0; py9 = -1; fs_cnt = 0; vob_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      if (vs_b != (v_b >= 10'd2)) vsb_bad++;
      if (vo_b && v_b >= 10'd10) vo_late++;
      if (vo_b) vob_cnt++;
      if (vo_b && v_b == 10'd9) py9 = int'(py_b);
      if (fs_b) fs_cnt++;
      tick(1);
    end
    chk("b_vs_shape", vsb_bad, 0);
    chk("b_vo_late", vo_late, 0);
    chk("b_vo_cnt", vob_cnt, 70);
    chk("b_py_last", py9, 6);
    chk("b_fs_cnt", fs_cnt, 1);
    chk("b_wrap_h", h_b, 0);
    chk("b_wrap_v", v_b, 0);
    chk("b_wrap_fs", fs_b, 1);

    // Drop enable at line 4, counting keeps going
    tick(80);
    en_b = 1'b0;
    tick(40);
    chk("b_drain_v", v_b, 6);
    chk("b_drain_h", h_b, 0);
    chk("b_drain_busy", bz_b, 1);
    // Re-assert during drain: no discontinuity, continues into next frame
    en_b = 1'b1;
    tick(1);
    chk("b_resume_h", h_b, 1);
    chk("b_resume_v", v_b, 6);
    tick(119);
    chk("b_next_h", h_b, 0);
    chk("b_next_v", v_b, 0);
    chk("b_next_fs", fs_b, 1);
    chk("b_next_vs", vs_b, 0);
    // Drop again and drain to idle
    en_b = 1'b0;
    tick(239);
    chk("b_last_h", h_b, 19);
    chk("b_last_v", v_b, 11);
    chk("b_last_le", le_b, 1);
    chk("b_last_busy", bz_b, 1);
    tick(1);
    chk("b_stop_h", h_b, 0);
    chk("b_stop_v", v_b, 0);
    chk("b_stop_hs", hs_b, 1);
    chk("b_stop_vs", vs_b, 1);
    chk("b_stop_busy", bz_b, 0);
    chk("b_stop_fs", fs_b, 0);
    tick(3);
    chk("b_stay_busy", bz_b, 0);
    chk("b_stay_h", h_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
